// File: rtl/alu_op_sequencer.sv
// Command FIFO plus IDLE/EXEC/RESP sequencer driving a shared 4-bit add/sub/compare datapath.
// Optional build macro: ALU_SEQ_RESERVED_TRAP_EN (trap op 11: dp_sel forced to 00, rsp_data 0, rsp_err 1).
module alu_op_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [3:0] req_a,
  input  logic [3:0] req_b,
  output logic [3:0] dp_a,
  output logic [3:0] dp_b,
  output logic [1:0] dp_sel,
  input  logic [3:0] dp_y,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_data,
  output logic [1:0] rsp_op,
  output logic       rsp_err,
  output logic       busy,
  output logic [7:0] cmpl_cnt,
  output logic [1:0] dbg_state
);

  // Handshakes: a transfer happens on the rising edge where valid && ready are both high.
  // A producer holds valid and its payload stable until that edge; ready never depends on valid.

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [CW-1:0] CNT_ONE = 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t        state;
  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic [1:0]    head_op;
  logic [3:0]    head_a;
  logic [3:0]    head_b;
  logic          head_trap;
  logic [1:0]    op_q;
  logic          trap_q;

  assign fifo_full  = (count == CNT_FULL);
  assign fifo_empty = (count == '0);
  assign req_ready  = !fifo_full;
  assign push       = req_valid && !fifo_full;
  // The sequencer is the only consumer; it pops in IDLE or on a response handshake.
  assign pop        = !fifo_empty && ((state == S_IDLE) || ((state == S_RESP) && rsp_ready));
  assign {head_op, head_a, head_b} = mem[rd_ptr];

`ifdef ALU_SEQ_RESERVED_TRAP_EN
  assign head_trap = (head_op == 2'b11);
`else
  assign head_trap = 1'b0;
`endif

  assign busy      = (state != S_IDLE) || !fifo_empty;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {req_op, req_a, req_b};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      dp_a      <= '0;
      dp_b      <= '0;
      dp_sel    <= '0;
      op_q      <= '0;
      trap_q    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_op    <= '0;
      rsp_err   <= 1'b0;
      cmpl_cnt  <= '0;
    end else begin
      // Operand/select load shares the pop condition in both IDLE and RESP.
      if (pop) begin
        dp_a   <= head_a;
        dp_b   <= head_b;
        dp_sel <= head_trap ? 2'b00 : head_op;
        op_q   <= head_op;
        trap_q <= head_trap;
      end
      case (state)
        S_IDLE: begin
          if (pop) state <= S_EXEC;
        end
        S_EXEC: begin
          rsp_data  <= trap_q ? 4'h0 : dp_y;
          rsp_op    <= op_q;
          rsp_err   <= trap_q;
          rsp_valid <= 1'b1;
          state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmpl_cnt  <= cmpl_cnt + 8'd1;
            state     <= pop ? S_EXEC : S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: models the datapath, keeps an expected-response queue and checks every cycle.
// Build with or without ALU_SEQ_RESERVED_TRAP_EN; expectations follow the same macro.
module tb_alu_op_sequencer;

  localparam int DEPTH = 4;
`ifdef ALU_SEQ_RESERVED_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [3:0] req_a;
  logic [3:0] req_b;
  logic [3:0] dp_a;
  logic [3:0] dp_b;
  logic [1:0] dp_sel;
  logic [3:0] dp_y;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_data;
  logic [1:0] rsp_op;
  logic       rsp_err;
  logic       busy;
  logic [7:0] cmpl_cnt;
  logic [1:0] dbg_state;

  alu_op_sequencer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .dp_a(dp_a), .dp_b(dp_b), .dp_sel(dp_sel), .dp_y(dp_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_op(rsp_op), .rsp_err(rsp_err),
    .busy(busy), .cmpl_cnt(cmpl_cnt), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- datapath model ----------------
  function automatic logic [3:0] dp_func(input logic [1:0] sel, input logic [3:0] a, input logic [3:0] b);
    case (sel)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return (a < b) ? 4'd1 : 4'd0;
      default: return a ^ b;
    endcase
  endfunction

  assign dp_y = dp_func(dp_sel, dp_a, dp_b);

  typedef struct packed {
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] data;
    logic [1:0] sel;
    logic       err;
  } exp_t;

  function automatic exp_t make_exp(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    exp_t e;
    logic trapped;
    trapped = TRAP && (op == 2'b11);
    e.op   = op;
    e.a    = a;
    e.b    = b;
    e.sel  = trapped ? 2'b00 : op;
    e.data = trapped ? 4'h0 : dp_func(op, a, b);
    e.err  = trapped;
    return e;
  endfunction

  // ---------------- scoreboard ----------------
  logic [16:0] exp_q[$];
  int          hs_cyc[$];
  logic [3:0]  hs_data[$];
  int          model_cnt = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  logic        hold = 1'b0;
  logic [6:0]  held = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_req_ready", req_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_cmpl_cnt", cmpl_cnt, 0);
      check("rst_dp", {dp_a, dp_b, dp_sel}, 0);
      check("rst_rsp", {rsp_data, rsp_op, rsp_err}, 0);
      exp_q.delete();
      model_cnt = 0;
      hold = 1'b0;
    end else begin
      check("busy", busy, (exp_q.size() != 0));
      check("cmpl_cnt", cmpl_cnt, model_cnt[7:0]);
      if (exp_q.size() < DEPTH) check("req_ready_free", req_ready, 1);
      else if (exp_q.size() == DEPTH + 1) check("req_ready_full", req_ready, 0);
      if (hold) begin
        check("rsp_valid_held", rsp_valid, 1);
        check("rsp_stable", {rsp_data, rsp_op, rsp_err}, held);
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_rsp", rsp_valid, 0);
        end else begin
          e = exp_q[0];
          check("rsp_data", rsp_data, e.data);
          check("rsp_op", rsp_op, e.op);
          check("rsp_err", rsp_err, e.err);
          check("dp_a", dp_a, e.a);
          check("dp_b", dp_b, e.b);
          check("dp_sel", dp_sel, e.sel);
          if (rsp_ready) begin
            void'(exp_q.pop_front());
            model_cnt++;
            hs_cyc.push_back(cyc);
            hs_data.push_back(rsp_data);
          end
        end
      end
      hold = rsp_valid && !rsp_ready;
      held = {rsp_data, rsp_op, rsp_err};
      if (req_valid && req_ready) exp_q.push_back(make_exp(req_op, req_a, req_b));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b, output int acc_cyc);
    int guard;
    guard = 0;
    req_valid = 1'b1;
    req_op = op;
    req_a = a;
    req_b = b;
    while (!req_ready && guard < 50) begin
      tick(1);
      guard++;
    end
    if (!req_ready) check("push_timeout", req_ready, 1);
    tick(1);
    acc_cyc = cyc;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
    tick(1);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int acc, a0, a1, a2, base, accepted, guard;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_op = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b1;
    tick(3);
    rst_n = 1'b1;
    check("post_rst_ready", req_ready, 1);
    check("post_rst_busy", busy, 0);
    check("post_rst_cnt", cmpl_cnt, 0);

    // Single add 3+5
    base = hs_cyc.size();
    push(2'b00, 4'd3, 4'd5, acc);
    tick(1);
    check("single_dp", {dp_sel, dp_a, dp_b}, {2'b00, 4'd3, 4'd5});
    tick(1);
    check("single_valid", rsp_valid, 1);
    check("single_data", rsp_data, 8);
    tick(1);
    check("single_cnt", cmpl_cnt, 1);
    check("single_busy", busy, 0);
    if (hs_cyc.size() > base) check("single_latency", hs_cyc[base] - acc, 2);

    // Back-to-back add, sub, compare
    base = hs_cyc.size();
    push(2'b00, 4'd9, 4'd4, a0);
    push(2'b01, 4'd9, 4'd4, a1);
    push(2'b10, 4'd2, 4'd7, a2);
    wait_drain(40);
    check("b2b_count", hs_cyc.size() - base, 3);
    if (hs_cyc.size() >= base + 3) begin
      check("b2b_lat", hs_cyc[base] - a0, 2);
      check("b2b_gap1", hs_cyc[base+1] - hs_cyc[base], 2);
      check("b2b_gap2", hs_cyc[base+2] - hs_cyc[base+1], 2);
      check("b2b_add", hs_data[base], 13);
      check("b2b_sub", hs_data[base+1], 5);
      check("b2b_cmp", hs_data[base+2], 1);
    end
    check("b2b_busy", busy, 0);

    // Backpressure until full
    base = hs_cyc.size();
    rsp_ready = 1'b0;
    accepted = 0;
    req_valid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      req_op = k[1:0];
      req_a = 4'(k + 1);
      req_b = 4'd2;
      if (!req_ready) break;
      tick(1);
      accepted++;
    end
    req_valid = 1'b0;
    check("full_accepted", accepted, DEPTH + 1);
    tick(5);
    check("full_ready", req_ready, 0);
    check("full_valid", rsp_valid, 1);
    rsp_ready = 1'b1;
    wait_drain(60);
    check("full_drained", hs_cyc.size() - base, DEPTH + 1);

    // Reserved op 11, a=7, b=1
    push(2'b11, 4'd7, 4'd1, acc);
    tick(1);
    check("rsv_dp_sel", dp_sel, TRAP ? 2'b00 : 2'b11);
    tick(1);
    check("rsv_valid", rsp_valid, 1);
    check("rsv_data", rsp_data, TRAP ? 4'd0 : 4'd6);
    check("rsv_err", rsp_err, TRAP ? 1 : 0);
    wait_drain(20);

    // Reset mid-flight while in RESP
    rsp_ready = 1'b0;
    push(2'b00, 4'd1, 4'd1, acc);
    push(2'b01, 4'd8, 4'd3, acc);
    push(2'b10, 4'd5, 4'd5, acc);
    guard = 0;
    while (!rsp_valid && guard < 20) begin
      tick(1);
      guard++;
    end
    check("midrst_in_resp", rsp_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", rsp_valid, 0);
    check("midrst_ready", req_ready, 1);
    check("midrst_busy", busy, 0);
    check("midrst_cnt", cmpl_cnt, 0);
    check("midrst_dp", {dp_a, dp_b, dp_sel}, 0);
    check("midrst_rsp", {rsp_data, rsp_op, rsp_err}, 0);
    tick(2);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    base = hs_cyc.size();
    tick(10);
    check("midrst_no_rsp", hs_cyc.size() - base, 0);
    check("midrst_idle", busy, 0);

    // Counter wrap over 256 completions
    for (int i = 0; i < 256; i++) begin
      push(2'(i % 4), i[3:0], i[7:4], acc);
    end
    wait_drain(300);
    check("wrap_model", model_cnt, 256);
    check("wrap_cnt", cmpl_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    n_errors++;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
